// File: rtl/state_display.sv
// Two-digit multiplexed 7-segment display stage for the counter/hold FSM.
// Shows 0-15 as decimal, blinks "16", shows "--" for hold and "EE" otherwise.
module state_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] state,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       led_done,
    output logic       led_hold
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] ERR   = 7'b0000110;
    localparam logic [6:0] ONE   = 7'b1111001;
    localparam logic [6:0] SIX   = 7'b0000010;

    logic [4:0]    state_q;
    logic          started;
    logic [RW-1:0] rcnt;
    logic          digit_sel;
    logic [BW-1:0] bcnt;
    logic          phase;

    logic          dec_lo, dec_hi, is16, is17, is_err;
    logic [6:0]    ones, tens, seg_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = BLANK;
        endcase
        return s;
    endfunction

    assign dec_lo = (state_q < 5'd10);
    assign dec_hi = (state_q >= 5'd10) && (state_q < 5'd16);
    assign is16   = (state_q == 5'd16);
    assign is17   = (state_q == 5'd17);
    assign is_err = (state_q >= 5'd18);

    always_comb begin
        ones = BLANK;
        tens = BLANK;
        unique case (1'b1)
            dec_lo: ones = seg7(state_q[3:0]);
            dec_hi: begin
                tens = ONE;
                ones = seg7(state_q[3:0] - 4'd10);
            end
            is16: begin
                tens = ONE;
                ones = SIX;
            end
            is17: begin
                tens = DASH;
                ones = DASH;
            end
            is_err: begin
                tens = ERR;
                ones = ERR;
            end
            default: ;
        endcase
        seg_d = digit_sel ? tens : ones;
        if (is16 && !phase) seg_d = BLANK;
    end

    // started holds the outputs at reset values for the first edge after
    // release, while state_q captures its first sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= '0;
            started   <= 1'b0;
            rcnt      <= '0;
            digit_sel <= 1'b0;
        end else begin
            state_q <= state;
            started <= 1'b1;
            if (started) begin
                if (rcnt == RMAX) begin
                    rcnt      <= '0;
                    digit_sel <= ~digit_sel;
                end else begin
                    rcnt <= rcnt + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (!is16) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (bcnt == BMAX) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt <= bcnt + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg      <= BLANK;
            an       <= 2'b11;
            led_done <= 1'b0;
            led_hold <= 1'b0;
        end else if (started) begin
            seg      <= seg_d;
            an       <= digit_sel ? 2'b01 : 2'b10;
            led_done <= is16;
            led_hold <= is17;
        end
    end

endmodule
